// File: rtl/ime_fisher_acc.sv
// Fisher-information packet accumulator: sums unsigned terms per packet and returns
// the total with term count and status flags. Define IME_FISHER_ACC_SAT_EN to saturate the sum.
module ime_fisher_acc #(
    parameter int unsigned W_ACC = 32,
    parameter int unsigned W_SUM = 48,
    parameter int unsigned K_MAX = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W_ACC-1:0]             in_term,
    input  logic                         in_last,
    input  logic                         in_poison,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W_SUM-1:0]             out_sum,
    output logic [$clog2(K_MAX+1)-1:0]   out_count,
    output logic                         out_poison,
    output logic                         out_overflow,
    output logic                         out_kmax_err
);

    localparam int unsigned W_CNT = $clog2(K_MAX + 1);
    localparam int unsigned W_ADD = W_SUM + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_SUM-1:0]   sum_q, sum_d;
    logic [W_CNT-1:0]   count_q, count_d;
    logic               poison_q, poison_d;
    logic               ovf_q, ovf_d;
    logic               kmax_q, kmax_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               release_hs;
    logic               at_kmax;
    logic               closing;
    logic [W_CNT-1:0]   count_inc;
    logic [W_ADD-1:0]   add_full;

    assign accept     = in_valid & in_ready_q;
    assign release_hs = out_valid_q & out_ready;
    assign count_inc  = count_q + W_CNT'(1);
    assign at_kmax    = (count_inc == W_CNT'(K_MAX));
    assign closing    = accept & (in_last | at_kmax);
    // Carry-out bit of the extended adder is the overflow indication.
    assign add_full   = {1'b0, sum_q} + W_ADD'(in_term);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (closing) begin
                    state_d = HOLD;
                end else if (accept) begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (release_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; accept and release are mutually exclusive
    always_comb begin
        sum_d       = sum_q;
        count_d     = count_q;
        poison_d    = poison_q;
        ovf_d       = ovf_q;
        kmax_d      = kmax_q;
        in_ready_d  = (state_d != HOLD);
        out_valid_d = (state_d == HOLD);
        if (release_hs) begin
            sum_d    = '0;
            count_d  = '0;
            poison_d = 1'b0;
            ovf_d    = 1'b0;
            kmax_d   = 1'b0;
        end else if (accept) begin
            count_d  = count_inc;
            poison_d = poison_q | in_poison;
            ovf_d    = ovf_q | add_full[W_SUM];
`ifdef IME_FISHER_ACC_SAT_EN
            sum_d    = (ovf_q | add_full[W_SUM]) ? '1 : add_full[W_SUM-1:0];
`else
            sum_d    = add_full[W_SUM-1:0];
`endif
            if (at_kmax && !in_last) begin
                kmax_d   = 1'b1;
                poison_d = 1'b1;
            end
        end
    end

    // Datapath and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= '0;
            count_q     <= '0;
            poison_q    <= 1'b0;
            ovf_q       <= 1'b0;
            kmax_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            count_q     <= count_d;
            poison_q    <= poison_d;
            ovf_q       <= ovf_d;
            kmax_q      <= kmax_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_sum      = sum_q;
    assign out_count    = count_q;
    assign out_poison   = poison_q;
    assign out_overflow = ovf_q;
    assign out_kmax_err = kmax_q;

endmodule

// File: tb/tb_ime_fisher_acc.sv
// Bench for ime_fisher_acc: a wide (32/48) and a narrow (8/8) instance share the same
// stimulus, both with K_MAX = 4, checked against a packet-level arithmetic model.
module tb_ime_fisher_acc;

    localparam int unsigned KM = 4;
    localparam int unsigned CW = $clog2(KM + 1);
    localparam int unsigned VA = 1 + 48 + CW + 3;
    localparam int unsigned VB = 1 + 8 + CW + 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_last, in_poison, out_ready;
    logic [31:0]   in_term;
    logic          a_in_ready, a_out_valid, a_poison, a_ovf, a_kmax;
    logic          b_in_ready, b_out_valid, b_poison, b_ovf, b_kmax;
    logic [47:0]   a_sum;
    logic [7:0]    b_sum;
    logic [CW-1:0] a_cnt, b_cnt;
    logic [VA-1:0] got_a, exp_a;
    logic [VB-1:0] got_b, exp_b;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    longint unsigned m_tot_a, m_tot_b;
    int unsigned     m_cnt;
    bit              m_poi;

    always #5 clk = ~clk;

    ime_fisher_acc #(.W_ACC(32), .W_SUM(48), .K_MAX(KM)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_term(in_term), .in_last(in_last), .in_poison(in_poison),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_sum),
        .out_count(a_cnt), .out_poison(a_poison), .out_overflow(a_ovf),
        .out_kmax_err(a_kmax)
    );

    ime_fisher_acc #(.W_ACC(8), .W_SUM(8), .K_MAX(KM)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_term(in_term[7:0]), .in_last(in_last), .in_poison(in_poison),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_sum),
        .out_count(b_cnt), .out_poison(b_poison), .out_overflow(b_ovf),
        .out_kmax_err(b_kmax)
    );

    assign got_a = {a_out_valid, a_sum, a_cnt, a_poison, a_ovf, a_kmax};
    assign got_b = {b_out_valid, b_sum, b_cnt, b_poison, b_ovf, b_kmax};

    // Reduce an exact packet total to a W-bit result
    function automatic void fold(input longint unsigned total, input int unsigned w,
                                 output longint unsigned s, output bit ovf);
        longint unsigned lim;
        lim = 64'd1 << w;
        ovf = (total >= lim);
`ifdef IME_FISHER_ACC_SAT_EN
        s = ovf ? lim - 64'd1 : total;
`else
        s = total % lim;
`endif
    endfunction

    function automatic void model_clear();
        m_tot_a = 0;
        m_tot_b = 0;
        m_cnt   = 0;
        m_poi   = 1'b0;
    endfunction

    function automatic void model_beat(input logic [31:0] term, input bit last,
                                       input bit poi, output bit closed);
        longint unsigned sa, sb;
        bit oa, ob, kerr;
        m_tot_a = m_tot_a + 64'(term);
        m_tot_b = m_tot_b + 64'(term[7:0]);
        m_cnt   = m_cnt + 1;
        m_poi   = m_poi | poi;
        closed  = last || (m_cnt == KM);
        if (closed) begin
            kerr = !last;
            fold(m_tot_a, 48, sa, oa);
            fold(m_tot_b, 8, sb, ob);
            exp_a = {1'b1, sa[47:0], CW'(m_cnt), m_poi | kerr, oa, kerr};
            exp_b = {1'b1, sb[7:0],  CW'(m_cnt), m_poi | kerr, ob, kerr};
            model_clear();
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_term = '0; in_last = 1'b0; in_poison = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // Drive one beat (waiting boundedly for in_ready), then scramble the idle inputs
    task automatic send(input logic [31:0] term, input bit last, input bit poi, output bit closed);
        int unsigned waitc;
        waitc = 0;
        while (a_in_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (a_in_ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready=%b required 1", a_in_ready);
        end
        in_valid = 1'b1; in_term = term; in_last = last; in_poison = poi;
        @(posedge clk); #1;
        in_valid = 1'b0; in_term = $urandom; in_last = 1'($urandom); in_poison = 1'($urandom);
        model_beat(term, last, poi, closed);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_term = 32'h1234; in_last = 1'b1; in_poison = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0)
            $display("FAIL reset_in_ready: got %b/%b required 0", a_in_ready, b_in_ready);
        else pass_cnt++;
        total_cnt++;
        if (got_a !== '0 || got_b !== '0)
            $display("FAIL reset_outputs: got %h/%h required 0", got_a, got_b);
        else pass_cnt++;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total_cnt++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
            $display("FAIL reset_release_ready: got %b/%b required 1", a_in_ready, b_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit c;
        out_ready = 1'b1;
        send(32'd3, 1'b0, 1'b0, c);
        send(32'd5, 1'b0, 1'b0, c);
        send(32'd7, 1'b1, 1'b0, c);
        total_cnt++;
        if (got_a !== {1'b1, 48'd15, CW'(3), 3'b000})
            $display("FAIL basic_a: got %h required %h", got_a, {1'b1, 48'd15, CW'(3), 3'b000});
        else pass_cnt++;
        total_cnt++;
        if (got_b !== exp_b) $display("FAIL basic_b: got %h required %h", got_b, exp_b);
        else pass_cnt++;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total_cnt++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
            $display("FAIL basic_release: got valid=%b ready=%b required 0/1", a_out_valid, a_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        bit c;
        bit ok;
        out_ready = 1'b0;
        send(32'd10, 1'b0, 1'b0, c);
        send(32'd20, 1'b0, 1'b1, c);
        send(32'd30, 1'b0, 1'b0, c);
        send(32'd40, 1'b1, 1'b0, c);
        total_cnt++;
        if (got_a !== exp_a || a_poison !== 1'b1 || a_kmax !== 1'b0)
            $display("FAIL hold_result: got %h required %h", got_a, exp_a);
        else pass_cnt++;
        ok = 1'b1;
        in_valid = 1'b1; in_term = 32'hDEAD; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) in_valid = 1'b0;
            @(posedge clk); #1;
            if (got_a !== exp_a || got_b !== exp_b || a_in_ready !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL hold_stable: got %h ready=%b required %h ready=0", got_a, a_in_ready, exp_a);
        else pass_cnt++;
        release_result();
        total_cnt++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_sum !== 48'd0)
            $display("FAIL hold_release: got valid=%b ready=%b sum=%h required 0/1/0",
                     a_out_valid, a_in_ready, a_sum);
        else pass_cnt++;
    endtask

    task automatic test_kmax();
        bit c;
        for (int i = 1; i <= 4; i++) send(32'(i * 100), 1'b0, 1'b0, c);
        total_cnt++;
        if (got_a !== exp_a || a_cnt !== CW'(4) || a_kmax !== 1'b1 || a_poison !== 1'b1)
            $display("FAIL kmax_first: got %h required %h", got_a, exp_a);
        else pass_cnt++;
        release_result();
        send(32'd11, 1'b0, 1'b0, c);
        send(32'd22, 1'b0, 1'b0, c);
        total_cnt++;
        if (a_out_valid !== 1'b0) $display("FAIL kmax_second_open: got valid=%b required 0", a_out_valid);
        else pass_cnt++;
        send(32'd33, 1'b1, 1'b0, c);
        total_cnt++;
        if (got_a !== exp_a || got_b !== exp_b || a_sum !== 48'd66)
            $display("FAIL kmax_second: got %h/%h required %h/%h", got_a, got_b, exp_a, exp_b);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_overflow();
        bit c;
        logic [7:0] req_sum;
`ifdef IME_FISHER_ACC_SAT_EN
        req_sum = 8'd255;
`else
        req_sum = 8'd44;
`endif
        send(32'd200, 1'b0, 1'b0, c);
        send(32'd100, 1'b1, 1'b0, c);
        total_cnt++;
        if (b_sum !== req_sum || b_ovf !== 1'b1 || got_b !== exp_b)
            $display("FAIL overflow_narrow: got sum=%0d ovf=%b required sum=%0d ovf=1", b_sum, b_ovf, req_sum);
        else pass_cnt++;
        total_cnt++;
        if (a_sum !== 48'd300 || a_ovf !== 1'b0)
            $display("FAIL overflow_wide: got sum=%0d ovf=%b required 300/0", a_sum, a_ovf);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_reset_mid();
        bit c;
        bit seen;
        send(32'd4, 1'b0, 1'b0, c);
        send(32'd6, 1'b0, 1'b0, c);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL reset_mid_no_result: got valid=1 required 0");
        else pass_cnt++;
        send(32'd9, 1'b1, 1'b0, c);
        total_cnt++;
        if (got_a !== {1'b1, 48'd9, CW'(1), 3'b000})
            $display("FAIL reset_mid_fresh: got %h required %h", got_a, {1'b1, 48'd9, CW'(1), 3'b000});
        else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        total_cnt++;
        if (got_a !== '0 || a_in_ready !== 1'b1)
            $display("FAIL reset_in_hold: got %h ready=%b required 0 ready=1", got_a, a_in_ready);
        else pass_cnt++;
    endtask

    task automatic test_single_max();
        bit c;
        send(32'hFFFF_FFFF, 1'b1, 1'b0, c);
        total_cnt++;
        if (a_sum !== 48'h0000_FFFF_FFFF || a_cnt !== CW'(1) || got_a !== exp_a)
            $display("FAIL single_max: got sum=%h cnt=%0d required 0000ffffffff/1", a_sum, a_cnt);
        else pass_cnt++;
        total_cnt++;
        if (got_b !== exp_b) $display("FAIL single_max_b: got %h required %h", got_b, exp_b);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_random();
        bit c;
        bit last, poi, ok;
        logic [31:0] term;
        int unsigned npkt;
        npkt = 0;
        while (npkt < 60) begin
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom);
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            case ($urandom_range(0, 3))
                0:       term = 32'd0;
                1:       term = 32'hFFFF_FFFF;
                default: term = $urandom;
            endcase
            last = ($urandom_range(0, 2) == 0);
            poi  = ($urandom_range(0, 5) == 0);
            send(term, last, poi, c);
            if (c) begin
                npkt++;
                total_cnt++;
                if (got_a !== exp_a || got_b !== exp_b)
                    $display("FAIL random_result[%0d]: got %h/%h required %h/%h",
                             npkt, got_a, got_b, exp_a, exp_b);
                else pass_cnt++;
                ok = 1'b1;
                repeat ($urandom_range(0, 3)) begin
                    in_valid = 1'($urandom);
                    @(posedge clk); #1;
                    if (got_a !== exp_a || got_b !== exp_b || a_in_ready !== 1'b0) ok = 1'b0;
                end
                in_valid = 1'b0;
                total_cnt++;
                if (!ok) $display("FAIL random_hold[%0d]: got %h required %h", npkt, got_a, exp_a);
                else pass_cnt++;
                release_result();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_kmax();
        test_overflow();
        test_reset_mid();
        test_single_max();
        do_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
